writeback_stage: RTL and testbench
==================================

# writeback_stage

Final pipeline stage of the RISC-V core: the producer side of the register-file write port that the decode stage consumes (`reg_write_addr_w`, `reg_write_en_w`, `reg_writedata_w`). It accepts one retiring instruction per cycle from the memory stage and selects the execute result or load data. It sign- or zero-extends sub-word loads, waits for late data-memory responses while stalling upstream, and flags misaligned loads and memory timeouts. It also keeps a retired-instruction counter.

## Interface
- `TIMEOUT_CYCLES`, 16: maximum cycles spent waiting for `dmem_rvalid` before a bus-timeout fault (≥2).
- `clk` input 1: core clock; all state updates on the rising edge.
- `rst_n` input 1: one clock; reset is asynchronous and active-low.
- `valid_m` input 1: memory stage presents an instruction.
- `reg_write_en_m` input 1: instruction writes a destination register.
- `reg_write_addr_m` input 5: destination register index.
- `reg_writedata_sel_m` input 1: 0 = execute result, 1 = load data.
- `execute_out_m` input 32: ALU/MUL/PC-adder result.
- `dmem_read_en_m` input 1: instruction is a load.
- `load_type_m` input 3: funct3 (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; others treated as LW).
- `byte_offset_m` input 2: load address bits [1:0].
- `dmem_rdata` input 32: word-aligned read data.
- `dmem_rvalid` input 1: read data valid this cycle.
- `flush_w` input 1: kill the instruction in this stage.
- `stall_w` output 1: upstream must hold `valid_m` and its payload.
- `reg_write_en_w` output 1: register-file write strobe, one cycle per commit.
- `reg_write_addr_w` output 5: write index.
- `reg_writedata_w` output 32: write data.
- `misaligned_w` output 1: one-cycle misaligned-load fault pulse.
- `timeout_w` output 1: one-cycle memory-timeout fault pulse.
- `retired_count_w` output 32: count of committed instructions.

## Operation
- States: IDLE, WAIT_MEM.
- An instruction is accepted when `valid_m && !stall_w && !flush_w`.
- `stall_w` is 1 exactly when the state is WAIT_MEM (Moore).
- Load classification: `dmem_read_en_m && reg_writedata_sel_m`. Everything else is a non-load, including stores, branches and instructions with `reg_write_en_m = 0`.
- IDLE, accepted non-load:
  - Commit `execute_out_m`.
  - Stay in IDLE.
- IDLE, accepted load:
  - If misaligned, no commit and no wait: pulse `misaligned_w` and stay in IDLE. Misaligned means LH/LHU with `byte_offset_m[0] = 1`, or LW with `byte_offset_m != 0`.
  - Otherwise, if `dmem_rvalid` is high the same cycle, commit the extended data and stay in IDLE.
  - Otherwise, latch addr, write-enable, type and offset, clear the wait counter, and go to WAIT_MEM.
- WAIT_MEM, on `dmem_rvalid`: commit the extended `dmem_rdata` with the latched metadata and go to IDLE.
- WAIT_MEM, timeout: when the counter reaches `TIMEOUT_CYCLES` with no `dmem_rvalid`, pulse `timeout_w`, skip the commit and go to IDLE.
- Commit actions:
  - `reg_write_en_w <= wen && addr != 0`, so writes to x0 are suppressed.
  - Address and data are loaded.
  - `retired_count_w` increments even if the write-enable is 0.
- Faulted and flushed instructions do not retire.
- Load extension:
  - LB/LBU take byte `byte_offset`. LH/LHU take the half selected by `offset[1]`.
  - LB/LH sign-extend; LBU/LHU zero-extend. LW passes the full word.
- Flush:
  - In IDLE, the presented instruction is discarded.
  - In WAIT_MEM, go to IDLE and discard any response in that cycle. Flush beats `dmem_rvalid` and the timeout.
- `dmem_rvalid` arriving in IDLE with no load accepted is ignored.
- `retired_count_w` wraps from 0xFFFF_FFFF to 0.

## Timing
- Reset values:
  - All outputs are 0; `stall_w` is 0.
  - State is IDLE; counters are 0.
  - Reset asserted in WAIT_MEM abandons the load; a later `dmem_rvalid` is ignored.
- Outputs are registered, except `stall_w`, which is decoded from the state register.
- Non-load, or load with same-cycle `rvalid`: accepted at edge N, write visible in cycle N+1 for exactly one cycle.
- Late load: `stall_w` is high from cycle N+1 until the cycle `dmem_rvalid` is sampled (edge M). Write and `stall_w = 0` appear in cycle M+1. Back-to-back acceptance resumes in cycle M+1.
- The wait counter increments on each WAIT_MEM cycle without `rvalid`. `timeout_w` pulses in the cycle after the `TIMEOUT_CYCLES`-th empty wait cycle, with `stall_w = 0` that same cycle.
- `misaligned_w` is high in cycle N+1 for one cycle.

## Test plan
- Reset, then ADD result 0x0000_1234 to x5, `valid_m` for one cycle → next cycle en=1, addr=5, data=0x1234, `retired_count_w` = 1.
- Back-to-back non-loads to x3, x0, x7 → three consecutive cycles: en=1/0/1, and count increases by 3.
- LB with offset 2, `dmem_rdata` = 0x0080_0000 with same-cycle `rvalid` → data 0xFFFF_FF80. LBU gives 0x0000_0080; LHU with offset 2 gives 0x0000_0080.
- Load with `rvalid` 3 cycles late → `stall_w` is high for 3 cycles, then the write. A following ADD held on `valid_m` commits the cycle after the load.
- Load with no response and `TIMEOUT_CYCLES` = 16 → `timeout_w` pulses after 16 stall cycles, with no write and unchanged count. Separately, LW with offset 1 gives a `misaligned_w` pulse and no stall.
- Load waiting with `flush_w` and `dmem_rvalid` in the same cycle → no write, IDLE the next cycle. Reset asserted mid-wait → all outputs 0 immediately.

Source files
------------

// File: rtl/writeback_stage.sv
// writeback_stage: retires one instruction per cycle into the register file,
// extending load data and waiting on late data-memory responses.
module writeback_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_m,
    input  logic        reg_write_en_m,
    input  logic [4:0]  reg_write_addr_m,
    input  logic        reg_writedata_sel_m,
    input  logic [31:0] execute_out_m,
    input  logic        dmem_read_en_m,
    input  logic [2:0]  load_type_m,
    input  logic [1:0]  byte_offset_m,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_rvalid,
    input  logic        flush_w,
    output logic        stall_w,
    output logic        reg_write_en_w,
    output logic [4:0]  reg_write_addr_w,
    output logic [31:0] reg_writedata_w,
    output logic        misaligned_w,
    output logic        timeout_w,
    output logic [31:0] retired_count_w
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic {
        IDLE,
        WAIT_MEM
    } state_t;

    state_t        state;
    logic [4:0]    addr_q;
    logic          wen_q;
    logic [2:0]    type_q;
    logic [1:0]    off_q;
    logic [CW-1:0] wait_cnt;

    logic          is_load;
    logic          accept;
    logic          misalign;
    logic          commit;
    logic          commit_wen;
    logic [4:0]    commit_addr;
    logic [31:0]   commit_data;

    function automatic logic [31:0] extend(
        input logic [31:0] w,
        input logic [2:0]  t,
        input logic [1:0]  off
    );
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{off, 3'b000} +: 8];
        h = off[1] ? w[31:16] : w[15:0];
        case (t)
            3'b000:  extend = {{24{b[7]}}, b};
            3'b001:  extend = {{16{h[15]}}, h};
            3'b100:  extend = {24'd0, b};
            3'b101:  extend = {16'd0, h};
            default: extend = w;
        endcase
    endfunction

    // Unlisted funct3 encodings behave as LW, including alignment.
    function automatic logic misaligned_ld(
        input logic [2:0] t,
        input logic [1:0] off
    );
        case (t)
            3'b000, 3'b100: misaligned_ld = 1'b0;
            3'b001, 3'b101: misaligned_ld = off[0];
            default:        misaligned_ld = (off != 2'd0);
        endcase
    endfunction

    assign stall_w  = (state == WAIT_MEM);
    assign is_load  = dmem_read_en_m & reg_writedata_sel_m;
    assign accept   = valid_m & ~stall_w & ~flush_w;
    assign misalign = misaligned_ld(load_type_m, byte_offset_m);

    always_comb begin
        commit      = 1'b0;
        commit_wen  = reg_write_en_m;
        commit_addr = reg_write_addr_m;
        commit_data = execute_out_m;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (!is_load) begin
                        commit = 1'b1;
                    end else if (!misalign && dmem_rvalid) begin
                        commit      = 1'b1;
                        commit_data = extend(dmem_rdata, load_type_m,
                                             byte_offset_m);
                    end
                end
            end
            WAIT_MEM: begin
                commit      = dmem_rvalid & ~flush_w;
                commit_wen  = wen_q;
                commit_addr = addr_q;
                commit_data = extend(dmem_rdata, type_q, off_q);
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            addr_q           <= 5'd0;
            wen_q            <= 1'b0;
            type_q           <= 3'd0;
            off_q            <= 2'd0;
            wait_cnt         <= '0;
            reg_write_en_w   <= 1'b0;
            reg_write_addr_w <= 5'd0;
            reg_writedata_w  <= 32'd0;
            misaligned_w     <= 1'b0;
            timeout_w        <= 1'b0;
            retired_count_w  <= 32'd0;
        end else begin
            reg_write_en_w <= commit & commit_wen & (commit_addr != 5'd0);
            misaligned_w   <= 1'b0;
            timeout_w      <= 1'b0;
            if (commit) begin
                reg_write_addr_w <= commit_addr;
                reg_writedata_w  <= commit_data;
                retired_count_w  <= retired_count_w + 32'd1;
            end
            unique case (state)
                IDLE: begin
                    if (accept && is_load) begin
                        if (misalign) begin
                            misaligned_w <= 1'b1;
                        end else if (!dmem_rvalid) begin
                            addr_q   <= reg_write_addr_m;
                            wen_q    <= reg_write_en_m;
                            type_q   <= load_type_m;
                            off_q    <= byte_offset_m;
                            wait_cnt <= '0;
                            state    <= WAIT_MEM;
                        end
                    end
                end
                WAIT_MEM: begin
                    // Flush wins over both a response and the timeout.
                    if (flush_w || dmem_rvalid) begin
                        state <= IDLE;
                    end else if (wait_cnt == WAIT_LAST) begin
                        timeout_w <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: scoreboard bench for writeback_stage commits,
// load extension, late loads, timeout, misalignment, flush and reset.
module tb_writeback_stage;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_m = 1'b0;
    logic        reg_write_en_m = 1'b0;
    logic [4:0]  reg_write_addr_m = '0;
    logic        reg_writedata_sel_m = 1'b0;
    logic [31:0] execute_out_m = '0;
    logic        dmem_read_en_m = 1'b0;
    logic [2:0]  load_type_m = '0;
    logic [1:0]  byte_offset_m = '0;
    logic [31:0] dmem_rdata = '0;
    logic        dmem_rvalid = 1'b0;
    logic        flush_w = 1'b0;
    logic        stall_w;
    logic        reg_write_en_w;
    logic [4:0]  reg_write_addr_w;
    logic [31:0] reg_writedata_w;
    logic        misaligned_w;
    logic        timeout_w;
    logic [31:0] retired_count_w;

    writeback_stage #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .valid_m(valid_m),
        .reg_write_en_m(reg_write_en_m),
        .reg_write_addr_m(reg_write_addr_m),
        .reg_writedata_sel_m(reg_writedata_sel_m),
        .execute_out_m(execute_out_m),
        .dmem_read_en_m(dmem_read_en_m),
        .load_type_m(load_type_m),
        .byte_offset_m(byte_offset_m),
        .dmem_rdata(dmem_rdata),
        .dmem_rvalid(dmem_rvalid),
        .flush_w(flush_w),
        .stall_w(stall_w),
        .reg_write_en_w(reg_write_en_w),
        .reg_write_addr_w(reg_write_addr_w),
        .reg_writedata_w(reg_writedata_w),
        .misaligned_w(misaligned_w),
        .timeout_w(timeout_w),
        .retired_count_w(retired_count_w)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        en;
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         obs_mem[256];
    int          obs_wr = 0;
    int          obs_rd = 0;
    logic [31:0] prev_cnt = '0;
    logic [31:0] exp_count = '0;
    int          checks = 0;
    int          errors = 0;

    // Record every commit (count step) and every write strobe.
    always @(negedge clk) begin
        if (rst_n && (retired_count_w != prev_cnt || reg_write_en_w)) begin
            obs_mem[obs_wr % 256] <= '{reg_write_en_w, reg_write_addr_w,
                                       reg_writedata_w};
            obs_wr <= obs_wr + 1;
        end
        prev_cnt <= retired_count_w;
    end

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        valid_m = 0; reg_write_en_m = 0; reg_write_addr_m = 0;
        reg_writedata_sel_m = 0; execute_out_m = 0; dmem_read_en_m = 0;
        load_type_m = 0; byte_offset_m = 0; dmem_rvalid = 0; flush_w = 0;
    endtask

    task automatic set_alu(input logic [4:0] a, input logic [31:0] d,
                           input logic en);
        valid_m = 1; reg_write_en_m = en; reg_write_addr_m = a;
        reg_writedata_sel_m = 0; execute_out_m = d; dmem_read_en_m = 0;
        load_type_m = 3'b000; byte_offset_m = 2'b11;
        dmem_rvalid = 0; flush_w = 0;
    endtask

    task automatic set_load(input logic [4:0] a, input logic [2:0] t,
                            input logic [1:0] off, input logic [31:0] rd,
                            input logic rv);
        valid_m = 1; reg_write_en_m = 1; reg_write_addr_m = a;
        reg_writedata_sel_m = 1; execute_out_m = 32'hBAD0_BAD0;
        dmem_read_en_m = 1; load_type_m = t; byte_offset_m = off;
        dmem_rdata = rd; dmem_rvalid = rv; flush_w = 0;
    endtask

    task automatic push_exp(input logic en, input logic [4:0] a,
                            input logic [31:0] d);
        exp_q.push_back('{en && (a != 5'd0), a, d});
        exp_count = exp_count + 32'd1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 0;
        repeat (3) cyc();
        checks++;
        if ({reg_write_en_w, reg_write_addr_w, reg_writedata_w} !== '0) begin
            errors++;
            $display("FAIL reset_write: got %0b/%0d/%h, expected 0/0/0",
                     reg_write_en_w, reg_write_addr_w, reg_writedata_w);
        end
        checks++;
        if ({stall_w, misaligned_w, timeout_w} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: got stall/mis/to=%b, expected 000",
                     {stall_w, misaligned_w, timeout_w});
        end
        checks++;
        if (retired_count_w !== 32'd0) begin
            errors++;
            $display("FAIL reset_count: got %0d, expected 0",
                     retired_count_w);
        end
        rst_n = 1;
        cyc();
    endtask

    task automatic test_alu();
        wr_t o, e;
        set_alu(5'd5, 32'h0000_1234, 1'b1);
        push_exp(1'b1, 5'd5, 32'h0000_1234);
        cyc();
        clear_inputs();
        checks++;
        if (reg_write_en_w !== 1'b1 || reg_write_addr_w !== 5'd5 ||
            reg_writedata_w !== 32'h1234 || retired_count_w !== 32'd1) begin
            errors++;
            $display("FAIL alu_commit: got en=%0b a=%0d d=%h cnt=%0d, %s",
                     reg_write_en_w, reg_write_addr_w, reg_writedata_w,
                     retired_count_w, "expected en=1 a=5 d=00001234 cnt=1");
        end
        cyc();
        checks++;
        if (reg_write_en_w !== 1'b0) begin
            errors++;
            $display("FAIL alu_one_cycle: got en=%0b, expected 0",
                     reg_write_en_w);
        end
        checks++;
        if (obs_wr - obs_rd != exp_q.size()) begin
            errors++;
            $display("FAIL alu_sb_count: got %0d writes, expected %0d",
                     obs_wr - obs_rd, exp_q.size());
        end
        while (exp_q.size() > 0 && obs_rd < obs_wr) begin
            o = obs_mem[obs_rd % 256]; obs_rd++;
            e = exp_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL alu_sb: got %0b/%0d/%h, expected %0b/%0d/%h",
                         o.en, o.addr, o.data, e.en, e.addr, e.data);
            end
        end
        exp_q.delete(); obs_rd = obs_wr;
    endtask

    task automatic test_back_to_back();
        wr_t o, e;
        logic [4:0] addrs[3] = '{5'd3, 5'd0, 5'd7};
        logic       ens[3]   = '{1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            set_alu(addrs[i], 32'hA000_0000 + 32'(i), 1'b1);
            push_exp(1'b1, addrs[i], 32'hA000_0000 + 32'(i));
            cyc();
            checks++;
            if (reg_write_en_w !== ens[i]) begin
                errors++;
                $display("FAIL b2b_en%0d: got %0b, expected %0b",
                         i, reg_write_en_w, ens[i]);
            end
        end
        clear_inputs();
        cyc();
        checks++;
        if (retired_count_w !== exp_count) begin
            errors++;
            $display("FAIL b2b_count: got %0d, expected %0d",
                     retired_count_w, exp_count);
        end
        checks++;
        if (obs_wr - obs_rd != exp_q.size()) begin
            errors++;
            $display("FAIL b2b_sb_count: got %0d writes, expected %0d",
                     obs_wr - obs_rd, exp_q.size());
        end
        while (exp_q.size() > 0 && obs_rd < obs_wr) begin
            o = obs_mem[obs_rd % 256]; obs_rd++;
            e = exp_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL b2b_sb: got %0b/%0d/%h, expected %0b/%0d/%h",
                         o.en, o.addr, o.data, e.en, e.addr, e.data);
            end
        end
        exp_q.delete(); obs_rd = obs_wr;
    endtask

    task automatic test_load_ext();
        wr_t o, e;
        logic [2:0]  ty[9]  = '{3'b000, 3'b100, 3'b101, 3'b001, 3'b001,
                                3'b000, 3'b010, 3'b011, 3'b100};
        logic [1:0]  off[9] = '{2, 2, 2, 2, 0, 3, 0, 0, 1};
        logic [31:0] rd[9]  = '{32'h0080_0000, 32'h0080_0000,
                                32'h0080_0000, 32'h8001_0000,
                                32'h0000_7FFE, 32'h7F00_0000,
                                32'hDEAD_BEEF, 32'h1234_5678,
                                32'h0000_A500};
        logic [31:0] ex[9]  = '{32'hFFFF_FF80, 32'h0000_0080,
                                32'h0000_0080, 32'hFFFF_8001,
                                32'h0000_7FFE, 32'h0000_007F,
                                32'hDEAD_BEEF, 32'h1234_5678,
                                32'h0000_00A5};
        for (int i = 0; i < 9; i++) begin
            set_load(5'(10 + i), ty[i], off[i], rd[i], 1'b1);
            push_exp(1'b1, 5'(10 + i), ex[i]);
            cyc();
            checks++;
            if (stall_w !== 1'b0) begin
                errors++;
                $display("FAIL ld_nostall%0d: got %0b, expected 0",
                         i, stall_w);
            end
        end
        clear_inputs();
        cyc();
        checks++;
        if (retired_count_w !== exp_count) begin
            errors++;
            $display("FAIL ld_count: got %0d, expected %0d",
                     retired_count_w, exp_count);
        end
        checks++;
        if (obs_wr - obs_rd != exp_q.size()) begin
            errors++;
            $display("FAIL ld_sb_count: got %0d writes, expected %0d",
                     obs_wr - obs_rd, exp_q.size());
        end
        while (exp_q.size() > 0 && obs_rd < obs_wr) begin
            o = obs_mem[obs_rd % 256]; obs_rd++;
            e = exp_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL ld_sb: got %0b/%0d/%h, expected %0b/%0d/%h",
                         o.en, o.addr, o.data, e.en, e.addr, e.data);
            end
        end
        exp_q.delete(); obs_rd = obs_wr;
    endtask

    task automatic test_late_load();
        wr_t o, e;
        int stall_n = 0;
        set_load(5'd9, 3'b101, 2'd2, 32'hFFFF_FFFF, 1'b0);
        push_exp(1'b1, 5'd9, 32'h0000_ABCD);
        for (int i = 0; i < 3; i++) begin
            cyc();
            if (i == 0) begin
                set_alu(5'd11, 32'h0000_0055, 1'b1);
                push_exp(1'b1, 5'd11, 32'h0000_0055);
            end
            if (stall_w) stall_n++;
            if (i == 2) begin
                dmem_rdata = 32'hABCD_1234;
                dmem_rvalid = 1;
            end
        end
        checks++;
        if (stall_n != 3) begin
            errors++;
            $display("FAIL late_stall: got %0d stall cycles, expected 3",
                     stall_n);
        end
        cyc();
        dmem_rvalid = 0;
        checks++;
        if (stall_w !== 1'b0 || reg_write_en_w !== 1'b1 ||
            reg_writedata_w !== 32'h0000_ABCD) begin
            errors++;
            $display("FAIL late_commit: got stall=%0b en=%0b d=%h, %s",
                     stall_w, reg_write_en_w, reg_writedata_w,
                     "expected stall=0 en=1 d=0000abcd");
        end
        cyc();
        clear_inputs();
        checks++;
        if (reg_write_en_w !== 1'b1 || reg_write_addr_w !== 5'd11) begin
            errors++;
            $display("FAIL late_follow: got en=%0b a=%0d, expected 1/11",
                     reg_write_en_w, reg_write_addr_w);
        end
        cyc();
        checks++;
        if (obs_wr - obs_rd != exp_q.size()) begin
            errors++;
            $display("FAIL late_sb_count: got %0d writes, expected %0d",
                     obs_wr - obs_rd, exp_q.size());
        end
        while (exp_q.size() > 0 && obs_rd < obs_wr) begin
            o = obs_mem[obs_rd % 256]; obs_rd++;
            e = exp_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL late_sb: got %0b/%0d/%h, expected %0b/%0d/%h",
                         o.en, o.addr, o.data, e.en, e.addr, e.data);
            end
        end
        exp_q.delete(); obs_rd = obs_wr;
    endtask

    task automatic test_timeout();
        int stall_n = 0;
        bit seen = 0;
        set_load(5'd12, 3'b010, 2'd0, 32'h0, 1'b0);
        cyc();
        clear_inputs();
        for (int i = 0; i < 40 && !seen; i++) begin
            if (timeout_w) begin
                seen = 1;
            end else begin
                if (stall_w) stall_n++;
                cyc();
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL to_pulse: got no timeout in 40 cycles, expected 1");
        end
        checks++;
        if (stall_n != TO) begin
            errors++;
            $display("FAIL to_stall: got %0d stall cycles, expected %0d",
                     stall_n, TO);
        end
        checks++;
        if (stall_w !== 1'b0 || reg_write_en_w !== 1'b0 ||
            retired_count_w !== exp_count) begin
            errors++;
            $display("FAIL to_state: got stall=%0b en=%0b cnt=%0d, %s%0d",
                     stall_w, reg_write_en_w, retired_count_w,
                     "expected 0/0/", exp_count);
        end
        cyc();
        checks++;
        if (timeout_w !== 1'b0) begin
            errors++;
            $display("FAIL to_width: got %0b one cycle later, expected 0",
                     timeout_w);
        end
    endtask

    task automatic test_misaligned();
        wr_t o, e;
        logic [2:0] ty[5]  = '{3'b010, 3'b001, 3'b101, 3'b111, 3'b001};
        logic [1:0] off[5] = '{1, 3, 1, 2, 2};
        logic       mis[5] = '{1, 1, 1, 1, 0};
        for (int i = 0; i < 5; i++) begin
            set_load(5'd4, ty[i], off[i], 32'h1122_3344, 1'b1);
            if (!mis[i]) push_exp(1'b1, 5'd4, 32'h0000_1122);
            cyc();
            checks++;
            if (misaligned_w !== mis[i] || stall_w !== 1'b0 ||
                reg_write_en_w !== !mis[i]) begin
                errors++;
                $display("FAIL mis%0d: got mis=%0b stall=%0b en=%0b, %s%0b",
                         i, misaligned_w, stall_w, reg_write_en_w,
                         "expected stall=0 mis=", mis[i]);
            end
        end
        set_load(5'd4, 3'b010, 2'd2, 32'h0, 1'b1);
        cyc();
        clear_inputs();
        cyc();
        checks++;
        if (misaligned_w !== 1'b0 || retired_count_w !== exp_count) begin
            errors++;
            $display("FAIL mis_after: got mis=%0b cnt=%0d, expected 0/%0d",
                     misaligned_w, retired_count_w, exp_count);
        end
        checks++;
        if (obs_wr - obs_rd != exp_q.size()) begin
            errors++;
            $display("FAIL mis_sb_count: got %0d writes, expected %0d",
                     obs_wr - obs_rd, exp_q.size());
        end
        while (exp_q.size() > 0 && obs_rd < obs_wr) begin
            o = obs_mem[obs_rd % 256]; obs_rd++;
            e = exp_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL mis_sb: got %0b/%0d/%h, expected %0b/%0d/%h",
                         o.en, o.addr, o.data, e.en, e.addr, e.data);
            end
        end
        exp_q.delete(); obs_rd = obs_wr;
    endtask

    task automatic test_flush();
        set_alu(5'd6, 32'h6666_6666, 1'b1);
        flush_w = 1;
        cyc();
        checks++;
        if (reg_write_en_w !== 1'b0 || stall_w !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle: got en=%0b stall=%0b, expected 0/0",
                     reg_write_en_w, stall_w);
        end
        set_load(5'd8, 3'b010, 2'd0, 32'h0, 1'b0);
        cyc();
        clear_inputs();
        cyc();
        checks++;
        if (stall_w !== 1'b1) begin
            errors++;
            $display("FAIL flush_wait: got stall=%0b, expected 1", stall_w);
        end
        flush_w = 1;
        dmem_rvalid = 1;
        dmem_rdata = 32'h8888_8888;
        cyc();
        clear_inputs();
        checks++;
        if (stall_w !== 1'b0 || reg_write_en_w !== 1'b0) begin
            errors++;
            $display("FAIL flush_mem: got stall=%0b en=%0b, expected 0/0",
                     stall_w, reg_write_en_w);
        end
        dmem_rvalid = 1;
        cyc();
        dmem_rvalid = 0;
        cyc();
        checks++;
        if (obs_wr != obs_rd || retired_count_w !== exp_count) begin
            errors++;
            $display("FAIL flush_nowrite: got %0d writes cnt=%0d, %s%0d",
                     obs_wr - obs_rd, retired_count_w,
                     "expected 0 writes cnt=", exp_count);
        end
        obs_rd = obs_wr;
    endtask

    task automatic test_reset_midwait();
        set_load(5'd13, 3'b010, 2'd0, 32'h0, 1'b0);
        cyc();
        clear_inputs();
        cyc();
        checks++;
        if (stall_w !== 1'b1) begin
            errors++;
            $display("FAIL rstw_wait: got stall=%0b, expected 1", stall_w);
        end
        rst_n = 0;
        exp_count = '0;
        #1;
        checks++;
        if ({stall_w, reg_write_en_w, reg_write_addr_w, reg_writedata_w,
             misaligned_w, timeout_w, retired_count_w} !== '0) begin
            errors++;
            $display("FAIL rstw_async: got stall=%0b cnt=%0d d=%h, %s",
                     stall_w, retired_count_w, reg_writedata_w,
                     "expected all zero");
        end
        cyc();
        rst_n = 1;
        dmem_rvalid = 1;
        dmem_rdata = 32'h1313_1313;
        cyc();
        dmem_rvalid = 0;
        checks++;
        if (stall_w !== 1'b0 || reg_write_en_w !== 1'b0 ||
            retired_count_w !== 32'd0) begin
            errors++;
            $display("FAIL rstw_stray: got stall=%0b en=%0b cnt=%0d, %s",
                     stall_w, reg_write_en_w, retired_count_w,
                     "expected 0/0/0");
        end
        set_alu(5'd2, 32'h0000_0002, 1'b1);
        cyc();
        clear_inputs();
        checks++;
        if (reg_write_en_w !== 1'b1 || retired_count_w !== 32'd1) begin
            errors++;
            $display("FAIL rstw_resume: got en=%0b cnt=%0d, expected 1/1",
                     reg_write_en_w, retired_count_w);
        end
        cyc();
        obs_rd = obs_wr;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_alu();
        test_back_to_back();
        test_load_ext();
        test_late_load();
        test_timeout();
        test_misaligned();
        test_flush();
        test_reset_midwait();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
